// File: rtl/ctrl_defuzzy.sv
// Sequencer for the type-2 fuzzy chain: enable windows for fuzzification and
// inference, then a restoring centroid divide (num/den) into a saturated output register.
module ctrl_defuzzy #(
  parameter int SETTLE_FUZ = 2,
  parameter int SETTLE_INF = 2,
  parameter int NUM_W      = 18,
  parameter int DEN_W      = 11,
  parameter int OUT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             EN_fuzzificador,
  output logic             EN_inferencia,
  output logic             EN_defuzzificador,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] saida,
  output logic             div_zero,
  output logic             ovf
);

  typedef enum logic [2:0] {
    S_IDLE, S_FUZ, S_INF, S_LOAD, S_DIV, S_OUT
  } state_t;

  localparam int SET_MAX = (SETTLE_FUZ > SETTLE_INF) ? SETTLE_FUZ : SETTLE_INF;
  localparam int CNT_MAX = (SET_MAX > NUM_W) ? SET_MAX : NUM_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] FUZ_LAST = CNT_W'(SETTLE_FUZ - 1);
  localparam logic [CNT_W-1:0] INF_LAST = CNT_W'(SETTLE_INF - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(NUM_W - 1);

  // Quotient does not fit the output register when any bit above OUT_W is set.
  function automatic logic is_ovf(input logic [NUM_W-1:0] q);
    return (q >> OUT_W) != '0;
  endfunction

  function automatic logic [OUT_W-1:0] sat_out(input logic [NUM_W-1:0] q);
    if (is_ovf(q)) return {OUT_W{1'b1}};
    return OUT_W'(q);
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               en_fuz_q, en_fuz_d;
  logic               en_inf_q, en_inf_d;
  logic               en_def_q, en_def_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [OUT_W-1:0]   saida_q, saida_d;
  logic               div_zero_q, div_zero_d;
  logic               ovf_q, ovf_d;

  // Divider datapath: quo holds the dividend and collects quotient bits as it shifts.
  logic [NUM_W-1:0]   quo_q, quo_d;
  logic [DEN_W-1:0]   dvs_q, dvs_d;
  logic [DEN_W:0]     rem_q, rem_d;
  logic [DEN_W:0]     rem_sh;

  always_comb begin
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    rem_sh = {rem_q[DEN_W-1:0], quo_q[NUM_W-1]};
    case (state_q)
      S_LOAD: begin
        quo_d = num;
        dvs_d = den;
        rem_d = '0;
      end
      S_DIV: begin
        quo_d = {quo_q[NUM_W-2:0], 1'b0};
        if (rem_sh >= {1'b0, dvs_q}) begin
          rem_d    = rem_sh - {1'b0, dvs_q};
          quo_d[0] = 1'b1;
        end else begin
          rem_d = rem_sh;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    saida_d    = saida_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_FUZ;
      end
      S_FUZ: begin
        if (cnt_q == FUZ_LAST) begin
          state_d = S_INF;
          cnt_d   = '0;
        end
      end
      S_INF: begin
        if (cnt_q == INF_LAST) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        cnt_d = '0;
        if (den == '0) begin
          state_d    = S_OUT;
          saida_d    = '0;
          div_zero_d = 1'b1;
          ovf_d      = 1'b0;
        end else begin
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        // quo_d already carries the final quotient bit on the last step.
        if (cnt_q == DIV_LAST) begin
          state_d    = S_OUT;
          cnt_d      = '0;
          saida_d    = sat_out(quo_d);
          ovf_d      = is_ovf(quo_d);
          div_zero_d = 1'b0;
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered copies of the next-state decode, so they track state_q.
    en_fuz_d = (state_d == S_FUZ);
    en_inf_d = (state_d == S_INF);
    en_def_d = (state_d == S_OUT);
    done_d   = (state_d == S_OUT);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      en_fuz_q   <= 1'b0;
      en_inf_q   <= 1'b0;
      en_def_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      saida_q    <= '0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      en_fuz_q   <= en_fuz_d;
      en_inf_q   <= en_inf_d;
      en_def_q   <= en_def_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      saida_q    <= saida_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
    end
  end

  // Divider registers are always reloaded in LOAD before use, so they carry no reset.
  always_ff @(posedge clk) begin
    quo_q <= quo_d;
    dvs_q <= dvs_d;
    rem_q <= rem_d;
  end

  assign EN_fuzzificador   = en_fuz_q;
  assign EN_inferencia     = en_inf_q;
  assign EN_defuzzificador = en_def_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign saida             = saida_q;
  assign div_zero          = div_zero_q;
  assign ovf               = ovf_q;

endmodule
